// File: rtl/tb_pkg.sv
// Shared constants for the traceback memory writer: array geometry, direction codes and FSM states.
package tb_pkg;

  localparam int B     = 4;
  localparam int L     = 8;
  localparam int DEPTH = 2*L - B;
  localparam int AW    = $clog2(DEPTH);

  // Depth as a 9-bit value so counters can reach DEPTH itself when DEPTH is 256
  localparam logic [8:0]    DEPTH_W   = 9'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [7:0]    NULL_BYTE = 8'h07;

  localparam logic [2:0] DIR_UP        = 3'b001;
  localparam logic [2:0] DIR_LEFT      = 3'b010;
  localparam logic [2:0] DIR_DIAG      = 3'b011;
  localparam logic [2:0] DIR_DIAG_WRAP = 3'b100;
  localparam logic [2:0] DIR_UP_WRAP   = 3'b101;
  localparam logic [2:0] DIR_LEFT_WRAP = 3'b110;
  localparam logic [2:0] DIR_NULL      = 3'b111;

  localparam logic [2:0] ENC_GAP       = 3'b100;
  localparam logic [2:0] ENC_BASE_NONE = 3'b111;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;

  function automatic logic [7:0] code_to_byte(input logic [2:0] code);
    return {5'b0, code};
  endfunction

endpackage

// File: rtl/tb_bank.sv
// One traceback bank: DEPTH bytes written sequentially by a single PE, with async read and null-fill port.
module tb_bank
  import tb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          wr_en_i,
  input  logic [2:0]    wr_code_i,
  input  logic          fill_en_i,
  input  logic [AW-1:0] fill_addr_i,
  input  logic [7:0]    rd_addr_i,
  output logic [7:0]    rd_data_o,
  output logic          ovf_o
);

  logic [7:0] mem_q [DEPTH];
  logic [8:0] wrCnt_q;
  logic       ovf_q;

  // A full bank drops the write and keeps the counter parked at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrCnt_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= NULL_BYTE;
      end
    end else begin
      if (clr_i) begin
        wrCnt_q <= '0;
        ovf_q   <= 1'b0;
      end else if (wr_en_i) begin
        if (wrCnt_q == DEPTH_W) begin
          ovf_q <= 1'b1;
        end else begin
          mem_q[wrCnt_q[AW-1:0]] <= code_to_byte(wr_code_i);
          wrCnt_q                <= wrCnt_q + 9'd1;
        end
      end
      if (fill_en_i) begin
        mem_q[fill_addr_i] <= NULL_BYTE;
      end
    end
  end

  assign rd_data_o = ({1'b0, rd_addr_i} < DEPTH_W) ? mem_q[rd_addr_i[AW-1:0]] : NULL_BYTE;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/tb_mem_writer.sv
// Traceback memory writer: captures per-PE direction codes into B banks and hands off to traceback.
// Optional macro TBW_NULL_FILL_EN adds a FILL phase that clears every bank to the null code on align_start.
module tb_mem_writer
  import tb_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           align_start,
  input  logic [B-1:0]   pe_valid,
  input  logic [3*B-1:0] pe_dir,
  input  logic           align_last,
  input  logic [1:0]     rd_pe_id,
  input  logic [7:0]     rd_addr,
  output logic [7:0]     rel_pos,
  output logic           start_traceback,
  input  logic           tb_finish,
  output logic           busy,
  output logic           overflow
);

  state_e        state_q;
  logic          start_q;
  logic          busy_q;
  logic [B-1:0]  bankOvf;
  logic [7:0]    rdData [B];
  logic          fillEn;
  logic [AW-1:0] fillAddr;

`ifdef TBW_NULL_FILL_EN
  logic [AW-1:0] fillCnt_q;
  assign fillEn   = (state_q == FILL);
  assign fillAddr = fillCnt_q;
`else
  assign fillEn   = 1'b0;
  assign fillAddr = '0;
`endif

  // align_start restarts from any state and wins over every other transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef TBW_NULL_FILL_EN
      fillCnt_q <= '0;
`endif
    end else if (align_start) begin
      start_q   <= 1'b0;
      busy_q    <= 1'b1;
`ifdef TBW_NULL_FILL_EN
      state_q   <= FILL;
      fillCnt_q <= '0;
`else
      state_q   <= WRITE;
`endif
    end else begin
      case (state_q)
        FILL: begin
`ifdef TBW_NULL_FILL_EN
          fillCnt_q <= fillCnt_q + AW'(1);
          if (fillCnt_q == LAST_ADDR) begin
            state_q <= WRITE;
          end
`else
          state_q <= IDLE;
          busy_q  <= 1'b0;
`endif
        end
        WRITE: begin
          if (align_last) begin
            state_q <= DONE;
            start_q <= 1'b1;
          end
        end
        DONE: begin
          if (tb_finish) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar p = 0; p < B; p++) begin : g_bank
    tb_bank u_bank (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (align_start),
      .wr_en_i     ((state_q == WRITE) && pe_valid[p] && !align_start),
      .wr_code_i   (pe_dir[3*p +: 3]),
      .fill_en_i   (fillEn),
      .fill_addr_i (fillAddr),
      .rd_addr_i   (rd_addr),
      .rd_data_o   (rdData[p]),
      .ovf_o       (bankOvf[p])
    );
  end

  assign rel_pos         = ({1'b0, rd_pe_id} < 3'(B)) ? rdData[rd_pe_id] : NULL_BYTE;
  assign start_traceback = start_q;
  assign busy            = busy_q;
  assign overflow        = |bankOvf;

endmodule
